ln_cordic_sequencer: RTL
========================

# ln_cordic_sequencer

Control FSM for the natural-logarithm unit's hyperbolic CORDIC datapath. It takes a start pulse, loads operands, and steps a 5-bit iteration counter. It supplies the per-cycle shift index and register enables to the datapath, repeats the iterations hyperbolic CORDIC requires for convergence, and holds a result-valid flag until the consumer acknowledges it.

## Interface
Parameters:
- `W`, default 5: iteration counter / shift-index width.
- `ITER`, default 24: last iteration index; legal range 1..2^W-1.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `BEG`  in  1  start request; sampled only in IDLE.
- `ACK`  in  1  consumer has taken the result; sampled only in DONE.
- `LOAD`  out  1  datapath loads initial X/Y/Z operands this cycle.
- `EN_ITER`  out  1  datapath performs one micro-rotation this cycle.
- `ITER_IDX`  out  W  shift amount i for the current micro-rotation.
- `REPEAT`  out  1  current micro-rotation is the second pass of a repeated index.
- `BUSY`  out  1  high in LOAD and ITER states.
- `RDY`  out  1  result valid; high in DONE state.

## Operation
- States: IDLE, LOAD, ITER, DONE. Encoding is free; all outputs are registered or decoded from registered state only, with no input-to-output combinational path.
- IDLE:
  - `BEG`=1 → LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `LOAD`=1 for exactly one cycle.
  - The counter is set to 1, and the repeat flag is cleared.
  - Always → ITER.
- ITER:
  - `EN_ITER`=1 and `ITER_IDX`=counter.
  - Repeat indices are 4 and 13, plus 40 when it fits within `ITER`. A repeat index is one where i ≤ `ITER`.
  - On the first pass of a repeat index: the counter holds, the repeat flag sets, and the index is issued again next cycle with `REPEAT`=1.
  - On the second pass: the repeat flag clears and the counter increments.
  - Non-repeat index: the counter increments.
  - When counter==`ITER` and no further pass of that index is pending → DONE.
- DONE:
  - `RDY`=1 and holds.
  - `ACK`=1 → IDLE, with `RDY` low on the next cycle.
- `BEG` outside IDLE is ignored. It is not queued.
- `ACK` outside DONE is ignored.
- If `BEG` and `ACK` are both high in DONE, only `ACK` acts. `BEG` needs a new assertion in IDLE.
- The counter never wraps, because `ITER` ≤ 2^W-1 is enforced by parameter choice. Counter arithmetic is W bits, unsigned.
- `ITER_IDX` is 0 outside ITER. `REPEAT` is 0 outside ITER.

## Timing
- Reset: state=IDLE. `LOAD`, `EN_ITER`, `REPEAT`, `BUSY` and `RDY` are 0, `ITER_IDX`=0, and the counter is 0.
- `RST` in any state aborts the operation on the next edge. It takes priority over `BEG`/`ACK`.
- `BEG` high at edge t:
  - `LOAD`/`BUSY` are high in cycle t+1.
  - The first `EN_ITER` (i=1) is in cycle t+2.
- ITER length is N = `ITER` + R cycles, where R is the number of repeat indices ≤ `ITER`.
- With `ITER`=24 and repeats enabled, N=26: indices 1,2,3,4,4,5..13,13,14..24.
- `RDY` rises in cycle t+2+N, which is t+28 for the defaults.
- The `BUSY` to `RDY` hand-over is seamless. `BUSY` falls in the same cycle `RDY` rises.
- Minimum restart: `ACK` at edge a → IDLE at a+1. A new `BEG` is accepted at edge a+1.

## Configuration
- Macro `LN_CORDIC_REPEAT_EN`.
- Defined: the repeat behaviour above applies (indices 4, 13, 40 within range). N = `ITER` + R.
- Undefined: every index 1..`ITER` is issued exactly once. `REPEAT` is tied 0 and N = `ITER`, which is 24 for the defaults with `RDY` at t+26.

## Test plan
- Reset mid-ITER:
  - Stimulus: BEG, run 10 cycles, assert `RST` for 1 cycle.
  - Response: next cycle all outputs 0, state IDLE, and no `RDY` ever appears. A subsequent BEG runs the full sequence normally.
- Nominal run, macro defined, `ITER`=24:
  - Stimulus: pulse `BEG` at t.
  - Response: `LOAD` at t+1, then `ITER_IDX` sequence 1,2,3,4,4,5,…,13,13,14,…,24, with `REPEAT`=1 only on the second 4 and the second 13. `RDY` at t+28 and held until `ACK`.
- Macro undefined, `ITER`=24:
  - Response: `ITER_IDX` is 1..24 once each, `REPEAT` is always 0, and `RDY` is at t+26.
- Handshake:
  - Stimulus: hold `ACK` low 5 cycles after `RDY`, then pulse `ACK` together with `BEG`.
  - Response: `RDY` stays high for 5 cycles, then drops. The state is IDLE and `BEG` is not acted on. A fresh `BEG` next cycle gives `LOAD` one cycle later.
- Ignored requests:
  - Stimulus: pulse `BEG` during ITER and pulse `ACK` during ITER.
  - Response: the sequence and timing are unchanged, and no second run occurs.
- Small `ITER`=3, macro defined:
  - Response: indices 1,2,3 with no repeats and `RDY` at t+5.
  - With `ITER`=4: indices 1,2,3,4,4 and `RDY` at t+7.

Source files
------------

// File: rtl/ln_cordic_sequencer.sv
//------------------------------------------------------------------------------
// ln_cordic_sequencer
//
// Control FSM for the natural-logarithm unit's hyperbolic CORDIC datapath.
// A start request loads the operands for one cycle. The FSM then issues the
// micro-rotations one per cycle, indices 1..ITER. Some indices are issued
// twice because hyperbolic CORDIC needs those repeats to converge. The result
// is then flagged valid until the consumer acknowledges it.
//
// Configuration macro:
//   LN_CORDIC_REPEAT_EN
//       Defined:   indices 4, 13 and 40 (those not above ITER) are issued twice.
//       Undefined: every index is issued once and REPEAT is tied low.
//
// Parameters:
//   W        iteration counter / shift-index width
//   ITER     last iteration index, 1 .. 2**W-1
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset, overrides BEG/ACK
//   BEG       in   start request, only sampled while idle
//   ACK       in   result taken, only sampled while the result is valid
//   LOAD      out  datapath loads the initial X/Y/Z operands this cycle
//   EN_ITER   out  datapath performs one micro-rotation this cycle
//   ITER_IDX  out  shift amount of the current micro-rotation (0 when idle)
//   REPEAT    out  current micro-rotation is the second pass of its index
//   BUSY      out  operand load or iterations in progress
//   RDY       out  result valid, held until ACK
//------------------------------------------------------------------------------
module ln_cordic_sequencer #(
    parameter int W    = 5,
    parameter int ITER = 24
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BEG,
    input  logic         ACK,
    output logic         LOAD,
    output logic         EN_ITER,
    output logic [W-1:0] ITER_IDX,
    output logic         REPEAT,
    output logic         BUSY,
    output logic         RDY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic [W-1:0] LAST = W'(ITER);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         rep_flag;
    logic         rep_nxt;
    logic         is_rep;

    // Decide whether the current index belongs to the repeat set. The
    // comparison is done at 32 bits so that index 40 is never aliased onto a
    // narrow counter. Repeat indices above ITER are excluded at elaboration.
`ifdef LN_CORDIC_REPEAT_EN
    always_comb begin
        is_rep = 1'b0;
        if ((ITER >= 4) && (32'(cnt) == 32'd4)) begin
            is_rep = 1'b1;
        end
        if ((ITER >= 13) && (32'(cnt) == 32'd13)) begin
            is_rep = 1'b1;
        end
        if ((ITER >= 40) && (32'(cnt) == 32'd40)) begin
            is_rep = 1'b1;
        end
    end
`else
    assign is_rep = 1'b0;
`endif

    // State, iteration counter and repeat flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rep_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rep_flag <= rep_nxt;
        end
    end

    // Next-state logic. On the first pass of a repeat index the counter holds
    // and the flag is set, so the same index is issued once more. Completion is
    // only possible once no second pass is pending for the last index.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rep_nxt   = rep_flag;
        case (state)
            S_IDLE: begin
                if (BEG) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_nxt   = W'(1);
                rep_nxt   = 1'b0;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                if (is_rep && !rep_flag) begin
                    rep_nxt = 1'b1;
                end else begin
                    rep_nxt = 1'b0;
                    if (cnt == LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt + W'(1);
                    end
                end
            end
            S_DONE: begin
                if (ACK) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only. There is no input-to-output path.
    assign LOAD     = (state == S_LOAD);
    assign EN_ITER  = (state == S_ITER);
    assign BUSY     = (state == S_LOAD) || (state == S_ITER);
    assign RDY      = (state == S_DONE);
    assign ITER_IDX = (state == S_ITER) ? cnt : '0;
`ifdef LN_CORDIC_REPEAT_EN
    assign REPEAT   = (state == S_ITER) && rep_flag;
`else
    assign REPEAT   = 1'b0;
`endif

endmodule
